sipo_deser: RTL
===============

Name: sipo_deser

Overview:
- Serial-to-parallel receiver: the far end of the LSB-first serial stream produced by the team's shift-register serializers.
- Each serial input bit is qualified by din_valid. Every WIDTH bits are assembled into one word.
- The word is presented on a parallel output with a valid/ready handshake and a one-word holding buffer.
- Sits between a serial link and a parallel consumer. Flags overrun when the consumer stalls.

Parameters:
- WIDTH, 8: bits per word; legal values ≥ 2.
- CNT_W, $clog2(WIDTH): bit-counter width. Derived; not to be overridden.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- din  input  1  serial data bit, LSB of each word first.
- din_valid  input  1  din is sampled on this edge only when high.
- sync_clr  input  1  synchronous abort: discards the partial word and re-aligns to a word boundary.
- dout  output  WIDTH  assembled word in the holding register.
- dout_valid  output  1  holding register full.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
- bit_cnt  output  CNT_W  bits received in the current partial word (0..WIDTH-1).
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (reset==0 at posedge): shift register = 0, bit_cnt = 0, dout = 0, dout_valid = 0, overrun = 0. Reset overrides every other input. A partial word in flight at reset is lost.
- Shift: on a posedge with din_valid=1 and sync_clr=0:
  - shreg <= {din, shreg[WIDTH-1:1]};
  - bit_cnt increments, wrapping WIDTH-1 -> 0.
- din_valid=0: shreg and bit_cnt hold. Gaps of any length between bits are legal.
- Word complete: din_valid=1 and bit_cnt==WIDTH-1 at a posedge.
  - Next word value is {din, shreg[WIDTH-1:1]}. The first bit received ends up in dout[0]; the last bit in dout[WIDTH-1].
- Holding register load, same edge as word complete:
  - If dout_valid==0, or a handshake (dout_valid && dout_ready) occurs this edge: dout <= next word, dout_valid <= 1.
  - Otherwise: word dropped, dout/dout_valid unchanged, overrun <= 1.
- Latency: dout_valid rises the clock after the edge that samples the last bit. A word can be consumed in the same cycle it becomes visible.
- Drain: handshake with no new word completing -> dout_valid <= 0 next edge. dout keeps its last value; it is don't-care while dout_valid=0.
- Simultaneous drain + completion: the new word replaces the old one, dout_valid stays 1, no overrun. This gives back-to-back throughput of one word per WIDTH valid bits with no bubble.
- sync_clr=1: bit_cnt <= 0, shreg <= 0.
  - A din_valid bit on the same edge is discarded.
  - The holding register, dout_valid and overrun are unaffected.
  - A handshake on that edge still completes normally.
- overrun: cleared only by reset.
- No combinational path from any input to dout_valid or dout. dout_ready only affects the next state.
- Control is counter-based, with two implicit phases:
  - ASSEMBLE: bit_cnt < WIDTH-1.
  - COMPLETE: bit_cnt == WIDTH-1; the next valid bit completes the word.

Decomposition:
- No shared package required. CNT_W is a localparam-derived constant inside the module.
- One natural sub-module: sipo_shift_core (WIDTH parameter).
  - Contents: shreg, bit_cnt and the word-complete pulse.
  - Inputs: clk, reset, din, din_valid, sync_clr.
  - Outputs: next_word, word_done.
- Handshake, holding register and overrun logic stay in sipo_deser.

Test Plan (WIDTH=4 instance):
- Basic: reset low 2 cycles, then din_valid=1 with din 1,0,1,1 on four consecutive edges, dout_ready=1 -> dout=4'b1101 and dout_valid=1 for exactly one cycle, bit_cnt back to 0, overrun=0.
- Gapped input: same bits with din_valid=0 for 3 cycles between bits 2 and 3 -> bit_cnt holds at 2 during the gap, final dout=4'b1101, dout_valid rises only after the 4th valid bit.
- Backpressure/overrun: dout_ready=0, send 4'b0011 then 4'b1010 -> dout stays 4'b0011, dout_valid=1, overrun=1. Then dout_ready=1 -> one handshake, dout_valid=0 next cycle, overrun remains 1.
- Back-to-back: dout_ready=1, continuous din_valid streaming 4'b0110 then 4'b1001 -> dout_valid high one cycle per word, values 4'b0110 then 4'b1001, overrun=0. A variant holds dout_ready=0 until the exact completion edge of word 2: still no overrun and dout=4'b1001.
- sync_clr mid-word: 2 bits sent, sync_clr=1 together with din_valid=1 -> bit_cnt=0, that bit ignored. Then 1,1,1,0 -> dout=4'b0111, and the earlier partial bits do not appear.
- Reset mid-operation: dout_valid=1 and bit_cnt=3 when reset=0 for 1 cycle -> dout=0, dout_valid=0, bit_cnt=0, overrun=0. The next 4 valid bits form a fresh word.

Source files
------------

// File: rtl/sipo_shift_core.sv
// LSB-first shift register and bit counter; flags the edge that completes a word.
module sipo_shift_core #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] next_word,
  output logic             word_done,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic             shift;

  assign shift     = din_valid && !sync_clr;
  // Word value as it would look after this edge's shift; only meaningful with word_done.
  assign next_word = {din, shreg[WIDTH-1:1]};
  assign word_done = shift && (bit_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (sync_clr) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      shreg   <= next_word;
      bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel receiver with a one-word valid/ready holding buffer and sticky overrun.
module sipo_deser #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  logic [WIDTH-1:0] next_word;
  logic             word_done;
  logic             handshake;

  sipo_shift_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .sync_clr  (sync_clr),
    .next_word (next_word),
    .word_done (word_done),
    .bit_cnt   (bit_cnt)
  );

  assign handshake = dout_valid && dout_ready;

  // A completing word may land in the buffer in the same edge the old one drains.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (word_done) begin
      if (!dout_valid || handshake) begin
        dout       <= next_word;
        dout_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (handshake) begin
      dout_valid <= 1'b0;
    end
  end

endmodule
